// File: rtl/mcdf_arbiter_n.sv
// mcdf_arbiter_n: picks one of CH_NUM slave channels by priority (0 = highest),
// latches its id and packet-length code, then streams that channel's beats to
// the formatter until the packet length has been acknowledged.
// Optional build macro MCDF_ARB_RR_EN: equal-priority ties rotate round-robin
// starting after the last granted channel; without it ties go to the lowest
// index and no pointer register exists.
module mcdf_arbiter_n #(
  parameter int CH_NUM = 4,
  parameter int DW     = 32,
  parameter int PRIO_W = 2,
  parameter int LEN_W  = 3
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [CH_NUM*PRIO_W-1:0] slv_prio_i,
  input  logic [CH_NUM*LEN_W-1:0]  slv_pkglen_i,
  input  logic [CH_NUM*DW-1:0]     slv_data_i,
  input  logic [CH_NUM-1:0]        slv_req_i,
  input  logic [CH_NUM-1:0]        slv_val_i,
  input  logic                     f2a_id_req_i,
  input  logic                     f2a_ack_i,
  output logic [CH_NUM-1:0]        a2s_ack_o,
  output logic                     a2f_val_o,
  output logic [(($clog2(CH_NUM) > 1) ? $clog2(CH_NUM) : 1)-1:0] a2f_id_o,
  output logic [DW-1:0]            a2f_data_o,
  output logic [LEN_W-1:0]         a2f_pkglen_sel_o
);

  localparam int ID_W = ($clog2(CH_NUM) > 1) ? $clog2(CH_NUM) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [ID_W-1:0]  win_id;
  logic [LEN_W-1:0] win_len;
  logic             beat;

`ifdef MCDF_ARB_RR_EN
  logic [ID_W-1:0]  ptr_q, ptr_d;
`endif

  // Index of the final beat for a length code (codes above 3 saturate to 32 beats).
  function automatic logic [5:0] last_beat_idx(input logic [LEN_W-1:0] code);
    case (int'(code))
      0:       return 6'd3;
      1:       return 6'd7;
      2:       return 6'd15;
      default: return 6'd31;
    endcase
  endfunction

  // Priority search: scan channels in tie-break order, keep strictly better priorities only.
  always_comb begin
    int                idx;
    logic              found;
    logic [PRIO_W-1:0] best;
    idx    = 0;
    found  = 1'b0;
    best   = '1;
    win_id = '0;
    for (int j = 0; j < CH_NUM; j++) begin
`ifdef MCDF_ARB_RR_EN
      idx = int'(ptr_q) + 1 + j;
      if (idx >= CH_NUM) idx = idx - CH_NUM;
`else
      idx = j;
`endif
      if (slv_req_i[idx] && (!found || (slv_prio_i[idx*PRIO_W +: PRIO_W] < best))) begin
        found  = 1'b1;
        best   = slv_prio_i[idx*PRIO_W +: PRIO_W];
        win_id = ID_W'(idx);
      end
    end
  end

  assign win_len = slv_pkglen_i[win_id*LEN_W +: LEN_W];

  // Beat datapath: only the granted channel is visible, and only while transferring.
  always_comb begin
    a2f_val_o  = 1'b0;
    a2f_data_o = '0;
    a2s_ack_o  = '0;
    if (state_q == XFER) begin
      a2f_val_o       = slv_val_i[id_q];
      a2f_data_o      = slv_data_i[id_q*DW +: DW];
      a2s_ack_o[id_q] = f2a_ack_i & slv_val_i[id_q];
    end
  end

  assign beat = a2f_val_o & f2a_ack_i;

  // Next-state logic: grant in IDLE, one dead cycle in GRANT, count beats in XFER.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
`ifdef MCDF_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (f2a_id_req_i && (|slv_req_i)) begin
          state_d = GRANT;
          id_d    = win_id;
          len_d   = win_len;
          cnt_d   = '0;
        end
      end
      GRANT: state_d = XFER;
      XFER: begin
        if (beat) begin
          if (cnt_q == last_beat_idx(len_q)) begin
            state_d = IDLE;
`ifdef MCDF_ARB_RR_EN
            ptr_d   = id_q;
`endif
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and grant registers; reset abandons any packet in flight.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
`ifdef MCDF_ARB_RR_EN
      ptr_q   <= ID_W'(CH_NUM - 1);
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
`ifdef MCDF_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign a2f_id_o         = id_q;
  assign a2f_pkglen_sel_o = len_q;

endmodule

// File: tb/tb_mcdf_arbiter_n.sv
// tb_mcdf_arbiter_n: directed bench for mcdf_arbiter_n with default parameters.
module tb_mcdf_arbiter_n;

  logic         clk;
  logic         rstn;
  logic [7:0]   slv_prio;
  logic [11:0]  slv_pkglen;
  logic [127:0] slv_data;
  logic [3:0]   slv_req;
  logic [3:0]   slv_val;
  logic         f2a_id_req;
  logic         f2a_ack;
  logic [3:0]   a2s_ack;
  logic         a2f_val;
  logic [1:0]   a2f_id;
  logic [31:0]  a2f_data;
  logic [2:0]   a2f_len;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  mcdf_arbiter_n dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .slv_prio_i       (slv_prio),
    .slv_pkglen_i     (slv_pkglen),
    .slv_data_i       (slv_data),
    .slv_req_i        (slv_req),
    .slv_val_i        (slv_val),
    .f2a_id_req_i     (f2a_id_req),
    .f2a_ack_i        (f2a_ack),
    .a2s_ack_o        (a2s_ack),
    .a2f_val_o        (a2f_val),
    .a2f_id_o         (a2f_id),
    .a2f_data_o       (a2f_data),
    .a2f_pkglen_sel_o (a2f_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  prio;
    logic [11:0] len;
    int          eid;
    int          elen;
    int          ebeats;
    int          evalhi;
    bit          tog;
    int          gap_at;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input int ch, input int c);
    return {4'hA, 4'(ch), 24'(c)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 4; k++) slv_data[k*32 +: 32] = data_of(k, cyc);
  endtask

  // One full packet: arbitration edge, GRANT cycle, XFER beats, return to IDLE.
  task automatic do_packet(input string nm, input int eid, input int elen, input int ebeats,
                           input int evalhi, input bit tog, input int gap_at);
    int         beats, cycles, gap_left, valhi, ackp, f0;
    bit         gap_done, bad, val_g, ackv;
    logic [3:0] req_save;
    logic [3:0] exp_ack;
    beats = 0; cycles = 0; gap_left = 0; valhi = 0; ackp = 0;
    gap_done = 1'b0; bad = 1'b0;
    slv_val = 4'hF; f2a_ack = 1'b1; f2a_id_req = 1'b1;
    tick();
    f2a_id_req = 1'b0;
    #1;
    check({nm, "_id"},        32'(a2f_id),   32'(eid));
    check({nm, "_len"},       32'(a2f_len),  32'(elen));
    check({nm, "_grant_val"}, 32'(a2f_val),  32'(0));
    check({nm, "_grant_ack"}, 32'(a2s_ack),  32'(0));
    req_save = slv_req;
    tick();
    slv_req = 4'h0;
    f2a_id_req = 1'b1;
    while (beats < ebeats && cycles < 200 && !bad) begin
      if (!gap_done && gap_at >= 0 && beats == gap_at) begin
        gap_left = 5;
        gap_done = 1'b1;
      end
      val_g = (gap_left == 0);
      slv_val = 4'hF;
      slv_val[eid] = val_g;
      ackv = tog ? cycles[0] : 1'b1;
      f2a_ack = ackv;
      #1;
      f0 = n_fail;
      exp_ack = (val_g && ackv) ? 4'(1 << eid) : 4'h0;
      check({nm, "_val"}, 32'(a2f_val), 32'(val_g));
      check({nm, "_ack"}, 32'(a2s_ack), 32'(exp_ack));
      if (val_g) check({nm, "_data"}, a2f_data, data_of(eid, cyc));
      if (n_fail != f0) bad = 1'b1;
      if (a2f_val) valhi++;
      if (a2s_ack[eid]) ackp++;
      if (val_g && ackv) beats++;
      if (gap_left > 0) gap_left--;
      cycles++;
      tick();
    end
    f2a_id_req = 1'b0;
    slv_req = req_save;
    slv_val = 4'hF; f2a_ack = 1'b1;
    #1;
    check({nm, "_beats"},    32'(beats),  32'(ebeats));
    check({nm, "_valhi"},    32'(valhi),  32'(evalhi));
    check({nm, "_ackpulse"}, 32'(ackp),   32'(ebeats));
    check({nm, "_end_val"},  32'(a2f_val),  32'(0));
    check({nm, "_end_ack"},  32'(a2s_ack),  32'(0));
    check({nm, "_end_data"}, a2f_data,      32'(0));
    check({nm, "_hold_id"},  32'(a2f_id),   32'(eid));
    check({nm, "_hold_len"}, 32'(a2f_len),  32'(elen));
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_val"},  32'(a2f_val), 32'(0));
    check({nm, "_data"}, a2f_data,     32'(0));
    check({nm, "_ack"},  32'(a2s_ack), 32'(0));
    check({nm, "_id"},   32'(a2f_id),  32'(0));
    check({nm, "_len"},  32'(a2f_len), 32'(0));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[8];
    int   rr_exp[5];
    tbl[0] = '{4'b0010, 8'h04, 12'h000, 1, 0,  4,  4, 1'b0, -1};
    tbl[1] = '{4'b0101, 8'h02, 12'h042, 2, 1,  8,  8, 1'b0, -1};
    tbl[2] = '{4'b0001, 8'h02, 12'h042, 0, 2, 16, 16, 1'b0, -1};
    tbl[3] = '{4'b1000, 8'hC0, 12'h600, 3, 3, 32, 32, 1'b0, -1};
    tbl[4] = '{4'b1110, 8'h6C, 12'hC00, 3, 6, 32, 32, 1'b0, -1};
    tbl[5] = '{4'b0010, 8'h00, 12'h028, 1, 5, 32, 64, 1'b1, -1};
    tbl[6] = '{4'b0100, 8'h00, 12'h040, 2, 1,  8,  8, 1'b0,  3};
    tbl[7] = '{4'b1111, 8'h9B, 12'hE11, 2, 0,  4,  4, 1'b0, -1};
`ifdef MCDF_ARB_RR_EN
    rr_exp = '{0, 1, 2, 3, 0};
`else
    rr_exp = '{0, 0, 0, 0, 0};
`endif

    // Reset with every input active: nothing may leak through.
    rstn = 1'b0;
    slv_prio = 8'h00; slv_pkglen = 12'hFFF; slv_req = 4'hF; slv_val = 4'hF;
    f2a_id_req = 1'b1; f2a_ack = 1'b1;
    for (int k = 0; k < 4; k++) slv_data[k*32 +: 32] = data_of(k, 0);
    #2;
    check_all_zero("reset");
    tick();
    check_all_zero("reset_clk");
    f2a_id_req = 1'b0; slv_req = 4'h0;
    rstn = 1'b1;
    tick();
    check_all_zero("idle_after_reset");

    for (int i = 0; i < 8; i++) begin
      slv_req    = tbl[i].req;
      slv_prio   = tbl[i].prio;
      slv_pkglen = tbl[i].len;
      do_packet($sformatf("vec%0d", i), tbl[i].eid, tbl[i].elen, tbl[i].ebeats,
                tbl[i].evalhi, tbl[i].tog, tbl[i].gap_at);
    end

    // Reset during beat 3 of an 8-beat packet, then a complete packet.
    slv_req = 4'b0010; slv_prio = 8'h00; slv_pkglen = 12'h008;
    slv_val = 4'hF; f2a_ack = 1'b1; f2a_id_req = 1'b1;
    tick();
    f2a_id_req = 1'b0;
    tick();
    tick();
    tick();
    #1;
    check("midrst_pre_val", 32'(a2f_val), 32'(1));
    rstn = 1'b0;
    #1;
    check_all_zero("midrst_async");
    tick();
    check_all_zero("midrst_held");
    rstn = 1'b1;
    do_packet("post_rst", 1, 1, 8, 8, 1'b0, -1);

    // Equal priorities on all channels, continuous request.
    do_reset();
    slv_req = 4'hF; slv_prio = 8'h55; slv_pkglen = 12'h000;
    for (int i = 0; i < 5; i++) do_packet($sformatf("tie%0d", i), rr_exp[i], 0, 4, 4, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
